blob_bbox_stats: RTL and testbench
==================================

# blob_bbox_stats

Per-frame blob statistics accumulator placed directly downstream of the connected-components labeling stage. It consumes the 8-bit label stream (0 = background) with the same hsync/vsync pixel-position convention as the top level. For every label it accumulates a bounding box and pixel count. On frame end (vsync) it drains all non-empty entries over a valid/ready interface, clearing each entry as it is emitted.

## Interface
- LABEL_W, 8 — label width; must equal WORD_SIZE
- NUM_LABELS, 256 — table depth; label 0 is never stored
- COORD_W, 16 — x/y counter and bound width
- COUNT_W, 24 — pixel-count width, saturating
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- en  in  1  pixel valid; ignored on hsync/vsync cycles and outside ACCUM
- hsync  in  1  end of row: x←0, y←y+1
- vsync  in  1  end of frame: x←0, y←0, start drain
- label  in  LABEL_W  label of current pixel
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_label  out  LABEL_W  label of record
- out_xmin, out_xmax, out_ymin, out_ymax  out  COORD_W  inclusive bounds
- out_count  out  COUNT_W  pixel count
- busy  out  1  high in SCAN/EMIT
- frame_done  out  1  one-cycle pulse when drain completes
- dropped  out  1  sticky: pixel or vsync arrived during drain; cleared only by reset

## Operation
- States: ACCUM, SCAN, EMIT.
- ACCUM:
  - Priority is hsync > vsync > pixel.
  - A pixel with en=1 and label≠0 updates entry[label]:
    - If count==0: set xmin=xmax=x, ymin=ymax=y, count=1.
    - Otherwise: update min/max and increment count, saturating at 2^COUNT_W−1.
  - x increments on every non-sync cycle, whether or not en is high.
  - x and y wrap modulo 2^COORD_W.
  - vsync → SCAN with idx=1.
- SCAN:
  - Reads entry[idx].
  - If count==0: idx++ with no output.
  - Otherwise: latch the entry into the output registers → EMIT.
  - When idx==NUM_LABELS−1 is processed with count==0 → pulse frame_done → ACCUM.
- EMIT:
  - out_valid held high with outputs stable until out_ready.
  - On handshake: clear entry[idx] (count←0), out_valid←0.
  - If idx was last → frame_done → ACCUM; otherwise idx++ → SCAN.
- During SCAN/EMIT:
  - en pixels and vsync are discarded and set dropped.
  - hsync is ignored.
  - x=y=0 on return to ACCUM.
- Reset (including mid-drain):
  - State→ACCUM, x=y=0, all counts=0, idx=1.
  - out_valid=0, all out_* =0, busy=0, frame_done=0, dropped=0.
  - Bounds need no reset; they are initialised by the first pixel.

## Timing
- Table update is single-cycle read-modify-write. Back-to-back pixels with the same label must accumulate correctly; there is no stall.
- First out_valid at earliest 2 cycles after the vsync edge: 1 cycle to enter SCAN, 1 cycle to latch the entry.
- Each empty entry costs 1 cycle. Each emitted entry costs ≥2 cycles (SCAN + EMIT handshake).
- Drain time is at most (NUM_LABELS−1) + 2·(non-empty entries) + stall cycles.
- out_* are registered. out_valid must not drop without a handshake.

## Configuration
- BLOB_SUM_EN defined:
  - Adds out_sum_x and out_sum_y outputs, each COORD_W+COUNT_W wide, wrapping.
  - These accumulate Σx and Σy per label for centroid computation downstream.
  - Both are cleared with the entry on handshake.
- Undefined: the ports and their storage are absent; behaviour is otherwise identical.

## Structure
- Shared package/header (detect_pkg): LABEL_W, COORD_W, COUNT_W defaults, and the ACCUM/SCAN/EMIT state encoding.
- Sub-module blob_entry_update: combinational merge of one entry with (x, y). It produces the next min/max/count and sums, and is reused for the sums under BLOB_SUM_EN.

## Test plan
- Single pixel label 5 at x=3,y=2, then vsync, out_ready=1 → one record: label 5, bounds 3..3 / 2..2, count 1; then frame_done; no other records.
- 4×3 rectangle of label 7 at x=10..13, y=4..6, interleaved with background → xmin 10, xmax 13, ymin 4, ymax 6, count 12.
- Labels 2 and 9 present, out_ready low for 5 cycles on the first record → label 2 emitted first and held stable across the stall, then label 9, then frame_done.
- Pixel and vsync injected during EMIT → dropped=1. The next frame starts with the table empty except its own pixels.
- Assert reset_n mid-EMIT → out_valid=0 immediately (async). Then vsync with no pixels → no records, and frame_done after 255 SCAN cycles.
- Same-label pixels on consecutive cycles, with count near max (COUNT_W=4, 20 pixels) → count saturates at 15.

Source files
------------

// File: rtl/detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : detect_pkg
// Purpose  : Shared defaults and drain state encoding for the blob statistics
//            accumulator and its helper blocks.
// Revision : 1.0
// ============================================================================
package detect_pkg;

  localparam int LABEL_W_DEF    = 8;
  localparam int NUM_LABELS_DEF = 256;
  localparam int COORD_W_DEF    = 16;
  localparam int COUNT_W_DEF    = 24;

  // ACCUM: collecting pixels; SCAN: walking the table; EMIT: record on output
  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/blob_entry_update.sv
`default_nettype none
// ============================================================================
// Module   : blob_entry_update
// Purpose  : Combinational merge of one table entry with a pixel at (x, y):
//            next bounds, saturating count and (with BLOB_SUM_EN) the
//            wrapping coordinate sums. An entry with count 0 is treated as
//            empty, so its stale bounds/sums are replaced, not merged.
// Config   : BLOB_SUM_EN adds the sum inputs/outputs.
// Revision : 1.0
// ============================================================================
module blob_entry_update
  import detect_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic [COORD_W-1:0]         x_i,
  input  logic [COORD_W-1:0]         y_i,
  input  logic [COORD_W-1:0]         xmin_i,
  input  logic [COORD_W-1:0]         xmax_i,
  input  logic [COORD_W-1:0]         ymin_i,
  input  logic [COORD_W-1:0]         ymax_i,
  input  logic [COUNT_W-1:0]         count_i,
`ifdef BLOB_SUM_EN
  input  logic [COORD_W+COUNT_W-1:0] sum_x_i,
  input  logic [COORD_W+COUNT_W-1:0] sum_y_i,
  output logic [COORD_W+COUNT_W-1:0] sum_x_o,
  output logic [COORD_W+COUNT_W-1:0] sum_y_o,
`endif
  output logic [COORD_W-1:0]         xmin_o,
  output logic [COORD_W-1:0]         xmax_o,
  output logic [COORD_W-1:0]         ymin_o,
  output logic [COORD_W-1:0]         ymax_o,
  output logic [COUNT_W-1:0]         count_o
);

  logic first;
  assign first = (count_i == '0);

  // Bounds widen to include the pixel; count saturates at all-ones
  always_comb begin
    xmin_o = (first || (x_i < xmin_i)) ? x_i : xmin_i;
    xmax_o = (first || (x_i > xmax_i)) ? x_i : xmax_i;
    ymin_o = (first || (y_i < ymin_i)) ? y_i : ymin_i;
    ymax_o = (first || (y_i > ymax_i)) ? y_i : ymax_i;
    if (first) begin
      count_o = COUNT_W'(1);
    end else if (&count_i) begin
      count_o = count_i;
    end else begin
      count_o = count_i + COUNT_W'(1);
    end
  end

`ifdef BLOB_SUM_EN
  localparam int SUM_W = COORD_W + COUNT_W;

  // Coordinate sums keep accumulating past count saturation and simply wrap
  always_comb begin
    sum_x_o = first ? SUM_W'(x_i) : sum_x_i + SUM_W'(x_i);
    sum_y_o = first ? SUM_W'(y_i) : sum_y_i + SUM_W'(y_i);
  end
`endif

endmodule
`default_nettype wire

// File: rtl/blob_bbox_stats.sv
`default_nettype none
// ============================================================================
// Module   : blob_bbox_stats
// Purpose  : Per-frame bounding box / pixel count accumulator on a label
//            stream. On vsync the table is drained in label order over a
//            valid/ready port, each entry cleared as it is accepted.
// Config   : BLOB_SUM_EN adds per-label sum-of-x / sum-of-y outputs.
// Revision : 1.0
// ============================================================================
module blob_bbox_stats
  import detect_pkg::*;
#(
  parameter int LABEL_W    = LABEL_W_DEF,
  parameter int NUM_LABELS = NUM_LABELS_DEF,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int COUNT_W    = COUNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic [LABEL_W-1:0]         label,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LABEL_W-1:0]         out_label,
  output logic [COORD_W-1:0]         out_xmin,
  output logic [COORD_W-1:0]         out_xmax,
  output logic [COORD_W-1:0]         out_ymin,
  output logic [COORD_W-1:0]         out_ymax,
  output logic [COUNT_W-1:0]         out_count,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       dropped
`ifdef BLOB_SUM_EN
  ,
  output logic [COORD_W+COUNT_W-1:0] out_sum_x,
  output logic [COORD_W+COUNT_W-1:0] out_sum_y
`endif
);

  localparam logic [LABEL_W-1:0] FIRST_IDX = LABEL_W'(1);
  localparam logic [LABEL_W-1:0] LAST_IDX  = LABEL_W'(NUM_LABELS - 1);

  // --------------------------------------------------------------------------
  // Control state and output registers
  // --------------------------------------------------------------------------
  state_e               state_q;
  logic [COORD_W-1:0]   x_q;
  logic [COORD_W-1:0]   y_q;
  logic [LABEL_W-1:0]   idx_q;
  logic                 out_valid_q;
  logic [LABEL_W-1:0]   out_label_q;
  logic [COORD_W-1:0]   out_xmin_q;
  logic [COORD_W-1:0]   out_xmax_q;
  logic [COORD_W-1:0]   out_ymin_q;
  logic [COORD_W-1:0]   out_ymax_q;
  logic [COUNT_W-1:0]   out_count_q;
  logic                 frame_done_q;
  logic                 dropped_q;

  // --------------------------------------------------------------------------
  // Label table. Counts are reset (count 0 marks an empty entry); bounds are
  // overwritten by the first pixel of a label, so they carry no reset.
  // --------------------------------------------------------------------------
  logic [COUNT_W-1:0]   cnt_q  [NUM_LABELS];
  logic [COORD_W-1:0]   xmin_q [NUM_LABELS];
  logic [COORD_W-1:0]   xmax_q [NUM_LABELS];
  logic [COORD_W-1:0]   ymin_q [NUM_LABELS];
  logic [COORD_W-1:0]   ymax_q [NUM_LABELS];

  // Single read port: pixel label while accumulating, scan index while draining
  logic [LABEL_W-1:0]   rd_addr;
  logic [COUNT_W-1:0]   rd_count;
  logic [COORD_W-1:0]   rd_xmin;
  logic [COORD_W-1:0]   rd_xmax;
  logic [COORD_W-1:0]   rd_ymin;
  logic [COORD_W-1:0]   rd_ymax;

  logic [COUNT_W-1:0]   count_d;
  logic [COORD_W-1:0]   xmin_d;
  logic [COORD_W-1:0]   xmax_d;
  logic [COORD_W-1:0]   ymin_d;
  logic [COORD_W-1:0]   ymax_d;

  logic                 in_accum;
  logic                 pix_we;
  logic                 clr_we;
  logic                 drop_evt;
  logic                 idx_last;

  assign in_accum = (state_q == ST_ACCUM);
  assign rd_addr  = in_accum ? label : idx_q;
  assign rd_count = cnt_q[rd_addr];
  assign rd_xmin  = xmin_q[rd_addr];
  assign rd_xmax  = xmax_q[rd_addr];
  assign rd_ymin  = ymin_q[rd_addr];
  assign rd_ymax  = ymax_q[rd_addr];

  // Sync cycles are never pixels; hsync outranks vsync which outranks en
  assign pix_we   = in_accum && en && !hsync && !vsync && (label != '0);
  assign clr_we   = (state_q == ST_EMIT) && out_valid_q && out_ready;
  assign drop_evt = vsync || (en && !hsync);
  assign idx_last = (idx_q == LAST_IDX);

`ifdef BLOB_SUM_EN
  localparam int SUM_W = COORD_W + COUNT_W;

  logic [SUM_W-1:0]     sumx_q [NUM_LABELS];
  logic [SUM_W-1:0]     sumy_q [NUM_LABELS];
  logic [SUM_W-1:0]     rd_sum_x;
  logic [SUM_W-1:0]     rd_sum_y;
  logic [SUM_W-1:0]     sum_x_d;
  logic [SUM_W-1:0]     sum_y_d;
  logic [SUM_W-1:0]     out_sum_x_q;
  logic [SUM_W-1:0]     out_sum_y_q;

  assign rd_sum_x  = sumx_q[rd_addr];
  assign rd_sum_y  = sumy_q[rd_addr];
  assign out_sum_x = out_sum_x_q;
  assign out_sum_y = out_sum_y_q;
`endif

  blob_entry_update #(
    .COORD_W (COORD_W),
    .COUNT_W (COUNT_W)
  ) u_merge (
    .x_i     (x_q),
    .y_i     (y_q),
    .xmin_i  (rd_xmin),
    .xmax_i  (rd_xmax),
    .ymin_i  (rd_ymin),
    .ymax_i  (rd_ymax),
    .count_i (rd_count),
`ifdef BLOB_SUM_EN
    .sum_x_i (rd_sum_x),
    .sum_y_i (rd_sum_y),
    .sum_x_o (sum_x_d),
    .sum_y_o (sum_y_d),
`endif
    .xmin_o  (xmin_d),
    .xmax_o  (xmax_d),
    .ymin_o  (ymin_d),
    .ymax_o  (ymax_d),
    .count_o (count_d)
  );

  // Entry counts: read-modify-write on a pixel, cleared when the record is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LABELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (pix_we) begin
      cnt_q[label] <= count_d;
    end else if (clr_we) begin
      cnt_q[idx_q] <= '0;
    end
  end

  // Entry bounds (and sums): written by pixels only, no reset needed
  always_ff @(posedge clk) begin
    if (pix_we) begin
      xmin_q[label] <= xmin_d;
      xmax_q[label] <= xmax_d;
      ymin_q[label] <= ymin_d;
      ymax_q[label] <= ymax_d;
`ifdef BLOB_SUM_EN
      sumx_q[label] <= sum_x_d;
      sumy_q[label] <= sum_y_d;
    end else if (clr_we) begin
      sumx_q[idx_q] <= '0;
      sumy_q[idx_q] <= '0;
`endif
    end
  end

  // Frame FSM: pixel position counters, table scan and registered record port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ACCUM;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= FIRST_IDX;
      out_valid_q  <= 1'b0;
      out_label_q  <= '0;
      out_xmin_q   <= '0;
      out_xmax_q   <= '0;
      out_ymin_q   <= '0;
      out_ymax_q   <= '0;
      out_count_q  <= '0;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;
`ifdef BLOB_SUM_EN
      out_sum_x_q  <= '0;
      out_sum_y_q  <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_ACCUM: begin
          if (hsync) begin
            x_q <= '0;
            y_q <= y_q + COORD_W'(1);
          end else if (vsync) begin
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= FIRST_IDX;
            state_q <= ST_SCAN;
          end else begin
            x_q <= x_q + COORD_W'(1);
          end
        end
        ST_SCAN: begin
          if (drop_evt) begin
            dropped_q <= 1'b1;
          end
          if (rd_count != '0) begin
            out_valid_q <= 1'b1;
            out_label_q <= idx_q;
            out_xmin_q  <= rd_xmin;
            out_xmax_q  <= rd_xmax;
            out_ymin_q  <= rd_ymin;
            out_ymax_q  <= rd_ymax;
            out_count_q <= rd_count;
`ifdef BLOB_SUM_EN
            out_sum_x_q <= rd_sum_x;
            out_sum_y_q <= rd_sum_y;
`endif
            state_q     <= ST_EMIT;
          end else if (idx_last) begin
            frame_done_q <= 1'b1;
            idx_q        <= FIRST_IDX;
            state_q      <= ST_ACCUM;
          end else begin
            idx_q <= idx_q + LABEL_W'(1);
          end
        end
        ST_EMIT: begin
          if (drop_evt) begin
            dropped_q <= 1'b1;
          end
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_last) begin
              frame_done_q <= 1'b1;
              idx_q        <= FIRST_IDX;
              state_q      <= ST_ACCUM;
            end else begin
              idx_q   <= idx_q + LABEL_W'(1);
              state_q <= ST_SCAN;
            end
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_label  = out_label_q;
  assign out_xmin   = out_xmin_q;
  assign out_xmax   = out_xmax_q;
  assign out_ymin   = out_ymin_q;
  assign out_ymax   = out_ymax_q;
  assign out_count  = out_count_q;
  assign busy       = !in_accum;
  assign frame_done = frame_done_q;
  assign dropped    = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_blob_bbox_stats.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_blob_bbox_stats
// Purpose  : Self-checking bench for blob_bbox_stats (COUNT_W=4 so count
//            saturation is reachable). Frames are described as small label
//            images; expected records are derived from the image directly.
// Config   : BLOB_SUM_EN also checks the coordinate sums.
// Revision : 1.0
// ============================================================================
module tb_blob_bbox_stats;

  localparam int LW  = 8;
  localparam int NL  = 256;
  localparam int CW  = 16;
  localparam int NW  = 4;
  localparam int SW  = CW + NW;
  localparam int MAXC = 15;
  localparam int ROWS_MAX = 8;
  localparam int COLS_MAX = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          hsync = 1'b0;
  logic          vsync = 1'b0;
  logic [LW-1:0] label = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [LW-1:0] out_label;
  logic [CW-1:0] out_xmin, out_xmax, out_ymin, out_ymax;
  logic [NW-1:0] out_count;
  logic          busy, frame_done, dropped;
`ifdef BLOB_SUM_EN
  logic [SW-1:0] out_sum_x, out_sum_y;
`endif

  always #5 clk = ~clk;

  blob_bbox_stats #(
    .LABEL_W    (LW),
    .NUM_LABELS (NL),
    .COORD_W    (CW),
    .COUNT_W    (NW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .label      (label),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_label  (out_label),
    .out_xmin   (out_xmin),
    .out_xmax   (out_xmax),
    .out_ymin   (out_ymin),
    .out_ymax   (out_ymax),
    .out_count  (out_count),
    .busy       (busy),
    .frame_done (frame_done),
    .dropped    (dropped)
`ifdef BLOB_SUM_EN
    ,
    .out_sum_x  (out_sum_x),
    .out_sum_y  (out_sum_y)
`endif
  );

  typedef struct {
    int     lbl;
    int     xmin, xmax, ymin, ymax;
    int     cnt;
    longint sx, sy;
  } rec_t;

  typedef struct {
    int lbl, x0, x1, y0, y1;
    int exmin, exmax, eymin, eymax, ecnt;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   rows, cols;
  int   img [ROWS_MAX][COLS_MAX];
  bit   msk [ROWS_MAX][COLS_MAX];
  rec_t expq[$];
  rec_t gotq[$];
  int   first_valid;
  int   last_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit e, input bit h, input bit v, input int l);
    en = e; hsync = h; vsync = v; label = LW'(l);
    step();
    en = 1'b0; hsync = 1'b0; vsync = 1'b0; label = '0;
  endtask

  task automatic clear_img(input int r, input int c);
    rows = r; cols = c;
    for (int y = 0; y < ROWS_MAX; y++)
      for (int x = 0; x < COLS_MAX; x++) begin
        img[y][x] = 0;
        msk[y][x] = 1'b1;
      end
  endtask

  // One row per image line (x from 0), hsync after each row, then vsync
  task automatic send_frame();
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < cols; x++) cyc(msk[y][x], 1'b0, 1'b0, img[y][x]);
      cyc(1'b0, 1'b1, 1'b0, 0);
    end
    cyc(1'b0, 1'b0, 1'b1, 0);
  endtask

  // Expected records straight from the image: per label extremes and totals
  task automatic build_expected();
    expq.delete();
    for (int l = 1; l < NL; l++) begin
      rec_t r;
      int n;
      n = 0;
      r.lbl = l; r.xmin = 1 << 30; r.ymin = 1 << 30; r.xmax = -1; r.ymax = -1;
      r.sx = 0; r.sy = 0; r.cnt = 0;
      for (int y = 0; y < rows; y++)
        for (int x = 0; x < cols; x++)
          if (msk[y][x] && img[y][x] == l) begin
            n++;
            if (x < r.xmin) r.xmin = x;
            if (x > r.xmax) r.xmax = x;
            if (y < r.ymin) r.ymin = y;
            if (y > r.ymax) r.ymax = y;
            r.sx += x; r.sy += y;
          end
      if (n > 0) begin
        r.cnt = (n > MAXC) ? MAXC : n;
        r.sx  = r.sx % (longint'(1) << SW);
        r.sy  = r.sy % (longint'(1) << SW);
        expq.push_back(r);
      end
    end
  endtask

  function automatic rec_t sample_out();
    rec_t r;
    r.lbl = int'(out_label); r.xmin = int'(out_xmin); r.xmax = int'(out_xmax);
    r.ymin = int'(out_ymin); r.ymax = int'(out_ymax); r.cnt = int'(out_count);
`ifdef BLOB_SUM_EN
    r.sx = longint'(out_sum_x); r.sy = longint'(out_sum_y);
`else
    r.sx = 0; r.sy = 0;
`endif
    return r;
  endfunction

  function automatic bit same(input rec_t a, input rec_t b);
    return a.lbl == b.lbl && a.xmin == b.xmin && a.xmax == b.xmax &&
           a.ymin == b.ymin && a.ymax == b.ymax && a.cnt == b.cnt &&
           a.sx == b.sx && a.sy == b.sy;
  endfunction

  // Starts one cycle after the vsync edge; collects records until frame_done
  task automatic drain(input bit rnd);
    rec_t r, held;
    bit   holding, done;
    int   n;
    holding = 1'b0; done = 1'b0; n = 0; first_valid = -1;
    gotq.delete();
    while (!done && n < 2000) begin
      if (holding) chk("hold_stable", {out_valid, same(sample_out(), held)}, 2'b11);
      if (out_valid && first_valid < 0) first_valid = n;
      if (frame_done) begin
        done = 1'b1;
        chk("busy_at_done", busy, 0);
      end else begin
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (out_valid) begin
          r = sample_out();
          if (out_ready) begin
            gotq.push_back(r);
            holding = 1'b0;
          end else begin
            held = r;
            holding = 1'b1;
          end
        end
        step();
        n++;
      end
    end
    out_ready = 1'b0;
    last_n = n;
    if (!done) chk("drain_timeout", 1, 0);
  endtask

  task automatic compare(input string tag, input bit lat);
    int m;
    chk({tag, "_nrec"}, gotq.size(), expq.size());
    m = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_label"}, gotq[i].lbl,  expq[i].lbl);
      chk({tag, "_xmin"},  gotq[i].xmin, expq[i].xmin);
      chk({tag, "_xmax"},  gotq[i].xmax, expq[i].xmax);
      chk({tag, "_ymin"},  gotq[i].ymin, expq[i].ymin);
      chk({tag, "_ymax"},  gotq[i].ymax, expq[i].ymax);
      chk({tag, "_count"}, gotq[i].cnt,  expq[i].cnt);
`ifdef BLOB_SUM_EN
      chk({tag, "_sumx"},  gotq[i].sx,   expq[i].sx);
      chk({tag, "_sumy"},  gotq[i].sy,   expq[i].sy);
`endif
    end
    // First record appears one cycle per skipped label after entering SCAN
    if (lat && expq.size() > 0) chk({tag, "_latency"}, first_valid, expq[0].lbl);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
    if (!out_valid) chk({tag, "_valid_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n;

    vecs[0] = '{5,   3,  3, 2, 2,   3,  3, 2, 2, 1};
    vecs[1] = '{7,  10, 13, 4, 6,  10, 13, 4, 6, 12};
    vecs[2] = '{255, 0,  0, 0, 0,   0,  0, 0, 0, 1};
    vecs[3] = '{1,   0,  4, 0, 3,   0,  4, 0, 3, 15};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_label", out_label, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Empty frame aligns x/y to 0 and walks all 255 entries
    step();
    cyc(1'b0, 1'b0, 1'b1, 0);
    chk("empty_busy", busy, 1);
    drain(1'b0);
    expq.delete();
    compare("empty", 1'b0);
    chk("empty_scan_cycles", last_n, 255);

    // Table-driven single-rectangle frames
    for (int v = 0; v < 4; v++) begin
      clear_img(vecs[v].y1 + 1, vecs[v].x1 + 2);
      for (int y = vecs[v].y0; y <= vecs[v].y1; y++)
        for (int x = vecs[v].x0; x <= vecs[v].x1; x++) img[y][x] = vecs[v].lbl;
      send_frame();
      drain(1'b0);
      chk("vec_nrec", gotq.size(), 1);
      if (gotq.size() > 0) begin
        chk("vec_label", gotq[0].lbl,  vecs[v].lbl);
        chk("vec_xmin",  gotq[0].xmin, vecs[v].exmin);
        chk("vec_xmax",  gotq[0].xmax, vecs[v].exmax);
        chk("vec_ymin",  gotq[0].ymin, vecs[v].eymin);
        chk("vec_ymax",  gotq[0].ymax, vecs[v].eymax);
        chk("vec_count", gotq[0].cnt,  vecs[v].ecnt);
        chk("vec_latency", first_valid, vecs[v].lbl);
      end
    end

    // Randomised frames against the image-level model, random backpressure
    for (int f = 0; f < 8; f++) begin
      int pool[4];
      pool[0] = 1; pool[1] = 255;
      pool[2] = $urandom_range(2, 254); pool[3] = $urandom_range(2, 254);
      clear_img($urandom_range(1, ROWS_MAX), $urandom_range(1, COLS_MAX));
      for (int y = 0; y < rows; y++)
        for (int x = 0; x < cols; x++) begin
          img[y][x] = ($urandom_range(0, 4) == 4) ? 0 : pool[$urandom_range(0, 3)];
          msk[y][x] = ($urandom_range(0, 3) != 0);
        end
      send_frame();
      build_expected();
      drain(1'b1);
      compare("rand", 1'b1);
    end
    chk("no_drop_yet", dropped, 0);

    // Stall on the first record: label 2 held stable, then label 9
    clear_img(1, 12);
    img[0][3] = 2; img[0][8] = 9;
    send_frame();
    wait_valid("stall", n);
    chk("stall_latency", n, 2);
    chk("stall_first_label", out_label, 2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid_held", out_valid, 1);
      chk("stall_label_held", out_label, 2);
      chk("stall_xmin_held", out_xmin, 3);
    end
    build_expected();
    drain(1'b0);
    compare("stall", 1'b0);

    // Pixel and vsync during EMIT are dropped
    clear_img(1, 6);
    img[0][1] = 3;
    send_frame();
    wait_valid("drop", n);
    cyc(1'b1, 1'b0, 1'b0, 4);
    chk("drop_set_pixel", dropped, 1);
    cyc(1'b0, 1'b0, 1'b1, 0);
    chk("drop_valid_held", out_valid, 1);
    chk("drop_label_held", out_label, 3);
    build_expected();
    drain(1'b0);
    compare("drop", 1'b0);
    clear_img(1, 5);
    img[0][2] = 6;
    send_frame();
    build_expected();
    drain(1'b1);
    compare("after_drop", 1'b1);
    chk("drop_sticky", dropped, 1);

    // Asynchronous reset in the middle of EMIT
    clear_img(1, 4);
    img[0][1] = 8;
    send_frame();
    wait_valid("areset", n);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_out_valid", out_valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_dropped", dropped, 0);
    chk("areset_out_count", out_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    cyc(1'b0, 1'b0, 1'b1, 0);
    drain(1'b0);
    expq.delete();
    compare("post_reset", 1'b0);
    chk("post_reset_scan_cycles", last_n, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
